// File: rtl/busPkg.sv
// Shared bus definitions: decoded slave indices, the read-return FSM states
// and the data value returned on a bus error.
package busPkg;

  localparam int RAM_IDX       = 0;
  localparam int UART_IDX      = 1;
  localparam int RANDOM_IDX    = 2;
  localparam int TIMER_IDX     = 3;
  localparam int SDRAM_IDX     = 4;
  localparam int SEQUENCER_IDX = 5;
  localparam int SAMPLE_IDX    = 6;
  localparam int IO_IDX        = 7;
  localparam int DACSPI_IDX    = 8;
  localparam int SOUND_IDX     = 9;
  localparam int SDCARDSPI_IDX = 10;
  localparam int I2C_IDX       = 11;

  localparam int NUM_SLAVES = 12;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIXED = 2'd1,
    WAIT_SDRAM = 2'd2,
    RESPOND    = 2'd3
  } readState_t;

  localparam logic [31:0] BUS_ERROR_DATA = 32'h0;

endpackage

// File: rtl/onehot_mux.sv
// One-hot select to data mux; isOneHot is low for an all-zero or multi-hot
// select so the caller can reject ambiguous decodes.
module onehot_mux #(
  parameter int WIDTH = 32,
  parameter int COUNT = 12
) (
  input  logic [COUNT-1:0]       sel,
  input  logic [COUNT*WIDTH-1:0] data,
  output logic [WIDTH-1:0]       dout,
  output logic                   isOneHot
);

  always_comb begin
    dout = '0;
    for (int i = 0; i < COUNT; i++) begin
      if (sel[i]) dout = dout | data[i*WIDTH +: WIDTH];
    end
  end

  // Clearing the lowest set bit leaves zero only when exactly one bit was set.
  assign isOneHot = (sel != '0) && ((sel & (sel - COUNT'(1))) == '0);

endmodule

// File: rtl/read_data_return.sv
// Read-response path: remembers which slave an accepted CPU read went to,
// waits out that slave's latency and returns one registered response pulse.
module read_data_return
  import busPkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int NUM_SLAVES     = busPkg::NUM_SLAVES
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     read,
  input  logic                     waitRequest,
  input  logic [NUM_SLAVES-1:0]    slaveSelect,
  input  logic [NUM_SLAVES*32-1:0] slaveReadData,
  input  logic                     sdramReadDataValid,
  output logic [31:0]              readData,
  output logic                     readDataValid,
  output logic                     busError,
  output logic                     busy,
  output readState_t               debug_state
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  readState_t            state;
  logic [NUM_SLAVES-1:0] selReg;
  logic                  errReg;
  logic [CNT_W-1:0]      cnt;

  logic [NUM_SLAVES-1:0] mux_sel;
  logic [31:0]           mux_data;
  logic                  sel_one_hot;
  logic                  accept;
  logic [31:0]           sdram_data;

  // In IDLE the mux validates the live decode; afterwards it steers the latched one.
  assign mux_sel    = (state == IDLE) ? slaveSelect : selReg;
  assign accept     = read && !waitRequest;
  assign sdram_data = slaveReadData[SDRAM_IDX*32 +: 32];

  onehot_mux #(
    .WIDTH (32),
    .COUNT (NUM_SLAVES)
  ) u_mux (
    .sel      (mux_sel),
    .data     (slaveReadData),
    .dout     (mux_data),
    .isOneHot (sel_one_hot)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      selReg        <= '0;
      errReg        <= 1'b0;
      cnt           <= '0;
      readData      <= '0;
      readDataValid <= 1'b0;
      busError      <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            selReg <= slaveSelect;
            busy   <= 1'b1;
            if (!sel_one_hot) begin
              errReg        <= 1'b1;
              readData      <= BUS_ERROR_DATA;
              readDataValid <= 1'b1;
              busError      <= 1'b1;
              state         <= RESPOND;
            end else if (slaveSelect[SDRAM_IDX]) begin
              cnt   <= '0;
              state <= WAIT_SDRAM;
            end else begin
              state <= WAIT_FIXED;
            end
          end
        end

        WAIT_FIXED: begin
          readData      <= mux_data;
          readDataValid <= 1'b1;
          busError      <= 1'b0;
          state         <= RESPOND;
        end

        WAIT_SDRAM: begin
          if (sdramReadDataValid) begin
            readData      <= sdram_data;
            readDataValid <= 1'b1;
            busError      <= 1'b0;
            state         <= RESPOND;
          end else if (cnt == CNT_LAST) begin
            errReg        <= 1'b1;
            readData      <= BUS_ERROR_DATA;
            readDataValid <= 1'b1;
            busError      <= 1'b1;
            state         <= RESPOND;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        RESPOND: begin
          readDataValid <= 1'b0;
          busError      <= 1'b0;
          errReg        <= 1'b0;
          busy          <= 1'b0;
          state         <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign debug_state = state;

endmodule

// File: tb/tb_read_data_return.sv
// Randomised bench for read_data_return: each read is predicted from the
// latency/error rules and checked cycle by cycle against the DUT.
module tb_read_data_return;
  import busPkg::*;

  localparam int TO = 16;
  localparam int NS = 12;

  logic             clk = 1'b0;
  logic             reset;
  logic             read;
  logic             waitRequest;
  logic [NS-1:0]    slaveSelect;
  logic [NS*32-1:0] slaveReadData;
  logic             sdramReadDataValid;
  logic [31:0]      readData;
  logic             readDataValid;
  logic             busError;
  logic             busy;
  readState_t       debug_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  read_data_return #(
    .TIMEOUT_CYCLES (TO),
    .NUM_SLAVES     (NS)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .read               (read),
    .waitRequest        (waitRequest),
    .slaveSelect        (slaveSelect),
    .slaveReadData      (slaveReadData),
    .sdramReadDataValid (sdramReadDataValid),
    .readData           (readData),
    .readDataValid      (readDataValid),
    .busError           (busError),
    .busy               (busy),
    .debug_state        (debug_state)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [NS*32-1:0] rand_bus();
    logic [NS*32-1:0] b;
    for (int i = 0; i < NS; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  // One read: optional stalls, accept, then k-th-cycle SDRAM strobe (0 = none).
  task automatic run_read(input logic [NS-1:0] sel, input int k, input int stalls,
                          input bit poke_busy, input logic [31:0] fixed_data,
                          input logic [31:0] sdram_data);
    int lat;
    int n;
    int idx;
    bit exp_err;
    logic [31:0] exp_data;

    idx = 0;
    for (int b = 0; b < NS; b++) if (sel[b]) idx = b;
    if (sel == '0 || $countones(sel) != 1) begin
      lat = 1; exp_err = 1'b1; exp_data = 32'h0;
    end else if (sel[SDRAM_IDX]) begin
      if (k >= 1 && k <= TO) begin
        lat = k + 1; exp_err = 1'b0; exp_data = sdram_data;
      end else begin
        lat = TO + 1; exp_err = 1'b1; exp_data = 32'h0;
      end
    end else begin
      lat = 2; exp_err = 1'b0; exp_data = fixed_data;
    end

    for (int s = 0; s < stalls; s++) begin
      @(posedge clk); #1;
      read = 1'b1; waitRequest = 1'b1; slaveSelect = sel;
      slaveReadData = rand_bus(); sdramReadDataValid = 1'b0;
    end
    @(posedge clk); #1;
    read = 1'b1; waitRequest = 1'b0; slaveSelect = sel;
    slaveReadData = rand_bus(); sdramReadDataValid = 1'b0;
    @(negedge clk);
    check("idle_before_accept", 32'(busy), 32'h0);
    exp_q.push_back(exp_data);

    n = (k > lat) ? k + 1 : lat;
    for (int j = 1; j <= n; j++) begin
      @(posedge clk); #1;
      read = poke_busy && (j == 1);
      waitRequest = 1'b0;
      slaveSelect = read ? NS'(1) : NS'($urandom);
      if (read) $display("note: read issued while busy (protocol violation, expected to be ignored)");
      slaveReadData = rand_bus();
      if (j == 1) slaveReadData[idx*32 +: 32] = fixed_data;
      sdramReadDataValid = (j == k);
      if (j == k) slaveReadData[SDRAM_IDX*32 +: 32] = sdram_data;
      @(negedge clk);
      check("valid", 32'(readDataValid), 32'(j == lat));
      check("busy", 32'(busy), 32'(j <= lat));
      if (j == lat) begin
        check("bus_error", 32'(busError), 32'(exp_err));
        check("read_data", readData, exp_q.pop_front());
      end
    end
    read = 1'b0;
  endtask

  task automatic reset_mid_read();
    @(posedge clk); #1;
    read = 1'b1; waitRequest = 1'b0; slaveSelect = NS'(1) << SDRAM_IDX;
    sdramReadDataValid = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      @(posedge clk); #1;
      read = 1'b0;
      reset = (j == 3);
      sdramReadDataValid = (j == 4);
      slaveReadData = rand_bus();
      @(negedge clk);
      check("rst_mid_valid", 32'(readDataValid), 32'h0);
      if (j <= 3) check("rst_mid_busy_pre", 32'(busy), 32'h1);
      if (j == 4) begin
        check("rst_mid_busy_post", 32'(busy), 32'h0);
        check("rst_mid_state", 32'(debug_state), 32'(IDLE));
        check("rst_mid_data", readData, 32'h0);
      end
    end
  endtask

  initial begin
    logic [NS-1:0] sel;
    int kind;
    int b;
    int c;

    reset = 1'b1; read = 1'b0; waitRequest = 1'b0; slaveSelect = '0;
    slaveReadData = '0; sdramReadDataValid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_data", readData, 32'h0);
    check("rst_valid", 32'(readDataValid), 32'h0);
    check("rst_err", 32'(busError), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_state", 32'(debug_state), 32'(IDLE));
    @(posedge clk); #1;
    reset = 1'b0;

    run_read(12'h001, 0, 0, 1'b0, 32'h12345678, 32'h0);
    run_read(NS'(1) << SDRAM_IDX, 7, 0, 1'b0, 32'h0, 32'hCAFEF00D);
    run_read(NS'(1) << SDRAM_IDX, 20, 0, 1'b0, 32'h0, 32'hDEADBEEF);
    run_read(12'h000, 0, 0, 1'b0, 32'h0, 32'h0);
    run_read(12'h011, 0, 0, 1'b0, 32'h0, 32'h0);
    reset_mid_read();
    run_read(12'h001, 0, 0, 1'b0, 32'hA5A55A5A, 32'h0);
    run_read(12'h001, 0, 0, 1'b1, 32'h0BADF00D, 32'h0);
    run_read(NS'(1) << I2C_IDX, 0, 0, 1'b0, 32'h600DCAFE, 32'h0);
    run_read(NS'(1) << SDRAM_IDX, TO, 0, 1'b0, 32'h0, 32'h13579BDF);

    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 3);
      sel = '0;
      case (kind)
        0: begin
          b = $urandom_range(0, NS - 2);
          if (b >= SDRAM_IDX) b++;
          sel[b] = 1'b1;
        end
        1: sel[SDRAM_IDX] = 1'b1;
        2: sel = '0;
        default: begin
          b = $urandom_range(0, NS - 1);
          c = (b + $urandom_range(1, NS - 1)) % NS;
          sel = NS'($urandom);
          sel[b] = 1'b1;
          sel[c] = 1'b1;
        end
      endcase
      run_read(sel, (kind == 1) ? $urandom_range(1, TO + 3) : 0,
               $urandom_range(0, 2), 1'($urandom_range(0, 1)), $urandom, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/read_data_return.md
# read_data_return

Read-response path placed directly downstream of the system address decoder. It latches which slave was selected when a CPU read is accepted and waits that slave's latency. It then steers the slave's read data back to the CPU as a single-cycle `readDataValid` pulse. Unmapped, multi-selected and timed-out reads are closed with a bus error, so the CPU never waits indefinitely.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum number of cycles spent waiting for SDRAM read data.
- `NUM_SLAVES`, default 12: number of decoded slaves. Index order is fixed in the package.

Ports:
- `clk` in 1: system clock. This is the only clock.
- `reset` in 1: synchronous, active-high reset.
- `read` in 1: CPU read strobe, the same signal the decoder sees.
- `waitRequest` in 1: decoder stall. A read is accepted on a cycle with `read && !waitRequest`.
- `slaveSelect` in `NUM_SLAVES`: chip enables from the decoder, expected one-hot or zero.
- `slaveReadData` in `NUM_SLAVES`×32: packed per-slave read data.
- `sdramReadDataValid` in 1: SDRAM controller read-data strobe.
- `readData` out 32: returned data.
- `readDataValid` out 1: one-cycle pulse that qualifies `readData`.
- `busError` out 1: one-cycle pulse coincident with an error `readDataValid`.
- `busy` out 1: high while a read is outstanding. The CPU must not issue a read while `busy` is high.

## Operation
- States: `IDLE`, `WAIT_FIXED`, `WAIT_SDRAM`, `RESPOND`.
- In `IDLE`, on an accepted read:
  - Register `slaveSelect` into `selReg`.
  - If it is zero or multi-hot, set `errReg=1` and go to `RESPOND`.
  - If it selects the SDRAM index, clear the timeout counter and go to `WAIT_SDRAM`.
  - Otherwise go to `WAIT_FIXED`.
- `WAIT_FIXED`: capture `slaveReadData[idx(selReg)]` into `dataReg` and go to `RESPOND`. All non-SDRAM slaves present data exactly one cycle after accept.
- `WAIT_SDRAM`:
  - If `sdramReadDataValid` is high, capture the SDRAM data and go to `RESPOND`.
  - Otherwise increment the counter. If the counter reaches `TIMEOUT_CYCLES-1`, set `errReg=1` and `dataReg=0`, then go to `RESPOND`.
- `RESPOND`: drive `readDataValid=1` and `busError=errReg`, clear `errReg`, and return to `IDLE`.
- On error, `readData` is 32'h00000000.
- Writes are ignored entirely. Writes never change state.
- A read asserted while `busy` is high is ignored and is not queued. The bench flags it as a protocol violation.
- `sdramReadDataValid` arriving in any state other than `WAIT_SDRAM` is ignored, including a late pulse after a timeout.
- The counter is `$clog2(TIMEOUT_CYCLES+1)` bits wide and saturates. It never wraps.
- `readData` holds its last value between responses. It is meaningful only while `readDataValid` is high.

## Timing
- Reset values: state `IDLE`, `readData=0`, `readDataValid=0`, `busError=0`, `busy=0`, counter 0, `selReg=0`, `errReg=0`.
- Reset asserted mid-transaction aborts the read. No response is issued, and the state is `IDLE` on the cycle after reset.
- Fixed-latency slave: accept at cycle T, `readDataValid` at T+2.
- Unmapped or multi-hot select: accept at T, error response at T+1.
- SDRAM: valid strobe at cycle S, response at S+1. The earliest possible response is T+2.
- SDRAM timeout: with no strobe, the error response arrives at T+1+`TIMEOUT_CYCLES`.
- `busy` is high from T+1 up to and including the response cycle. The next read can be accepted in the cycle after the response.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Package `busPkg` holds:
  - the slave index constants (`RAM_IDX=0`, `UART_IDX=1`, `RANDOM_IDX=2`, `TIMER_IDX=3`, `SDRAM_IDX=4`, `SEQUENCER_IDX=5`, `SAMPLE_IDX=6`, `IO_IDX=7`, `DACSPI_IDX=8`, `SOUND_IDX=9`, `SDCARDSPI_IDX=10`, `I2C_IDX=11`);
  - `NUM_SLAVES`;
  - the state enum `readState_t`;
  - the error data constant `BUS_ERROR_DATA = 32'h0`.
- Sub-module `onehot_mux`, parameterised on width and count: one-hot select to data, plus an `isOneHot` flag used for the multi-hot check.

## Test plan
- RAM read: accept with select `12'h001` and RAM data 32'h12345678 at T+1 -> `readData`=32'h12345678 and `readDataValid` at T+2, `busError=0`.
- SDRAM read: strobe 7 cycles after accept with data 32'hCAFEF00D -> response 8 cycles after accept, `busy` high throughout.
- SDRAM timeout: `TIMEOUT_CYCLES=16` and no strobe -> `busError` and `readDataValid` at T+17 with `readData=0`; a late strobe at T+20 is ignored.
- Unmapped read: accept with select=0 -> error response at T+1; multi-hot `12'h011` -> same error response.
- Reset mid-read: `reset` high at T+3 of an SDRAM wait -> no `readDataValid`, and `busy=0` on the cycle after reset; the next RAM read returns normally.
- Back-to-back reads: a second read during `busy` is ignored; a read in the cycle after the response is accepted and completes at +2.
